// File: rtl/pipe_trace_if.sv
// pipe_trace_if: debug taps from the core, monitor control, trace stream and counters.
interface pipe_trace_if #(
    parameter int CNT_W = 32,
    parameter int TS_W  = 16
);
    logic [31:0]        debug_aluresult;
    logic               debug_regwrite_w;
    logic [4:0]         debug_rd_w;
    logic               debug_stall_f;
    logic               debug_stall_d;
    logic               debug_flush_d;
    logic               debug_flush_e;
    logic [1:0]         debug_forward_ae;
    logic [1:0]         debug_forward_be;
    logic               debug_pcsrc_e;
    logic               ctrl_start;
    logic               ctrl_stop;
    logic               ctrl_clear;
    logic               trace_valid;
    logic               trace_ready;
    logic [TS_W+36:0]   trace_data;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   retire_count;
    logic [CNT_W-1:0]   stall_count;
    logic [CNT_W-1:0]   flush_count;
    logic [CNT_W-1:0]   fwd_count;
    logic [CNT_W-1:0]   branch_count;
    logic [CNT_W-1:0]   drop_count;
    logic               overflow;
    logic [1:0]         state;

    modport master (
        output debug_aluresult, debug_regwrite_w, debug_rd_w, debug_stall_f, debug_stall_d,
               debug_flush_d, debug_flush_e, debug_forward_ae, debug_forward_be, debug_pcsrc_e,
               ctrl_start, ctrl_stop, ctrl_clear, trace_ready,
        input  trace_valid, trace_data, cycle_count, retire_count, stall_count, flush_count,
               fwd_count, branch_count, drop_count, overflow, state
    );

    modport slave (
        input  debug_aluresult, debug_regwrite_w, debug_rd_w, debug_stall_f, debug_stall_d,
               debug_flush_d, debug_flush_e, debug_forward_ae, debug_forward_be, debug_pcsrc_e,
               ctrl_start, ctrl_stop, ctrl_clear, trace_ready,
        output trace_valid, trace_data, cycle_count, retire_count, stall_count, flush_count,
               fwd_count, branch_count, drop_count, overflow, state
    );
endinterface

// File: rtl/pipe_trace_monitor.sv
// pipe_trace_monitor: timestamped retire trace FIFO plus saturating hazard counters for a pipelined core.
module pipe_trace_monitor #(
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 32,
    parameter int TS_W         = 16,
    parameter int STOP_ON_FULL = 0
) (
    input logic clk,
    input logic reset,
    pipe_trace_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;
    localparam int AW = $clog2(DEPTH);

    state_t st;
    logic [TS_W+36:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, occ;
    logic full, empty, pop, run, evt, push, drop;
    logic stall, flush, fwd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        occ   = wr_ptr - rd_ptr;
        full  = occ == (AW+1)'(DEPTH);
        empty = wr_ptr == rd_ptr;
        pop   = !empty && bus.trace_ready;
        run   = st == RUN;
        evt   = run && bus.debug_regwrite_w && bus.debug_rd_w != 5'd0;
        push  = evt && (!full || pop);
        drop  = evt && !push;
        stall = bus.debug_stall_f | bus.debug_stall_d;
        flush = bus.debug_flush_d | bus.debug_flush_e;
        fwd   = (bus.debug_forward_ae != 2'b00) || (bus.debug_forward_be != 2'b00);
    end

    assign bus.trace_valid = !empty;
    assign bus.trace_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.state       = st;

    // clear shares the reset path so a same-cycle event is discarded with everything else
    always_ff @(posedge clk) begin
        if (reset || bus.ctrl_clear) begin
            st               <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.cycle_count  <= '0;
            bus.retire_count <= '0;
            bus.stall_count  <= '0;
            bus.flush_count  <= '0;
            bus.fwd_count    <= '0;
            bus.branch_count <= '0;
            bus.drop_count   <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {bus.cycle_count[TS_W-1:0], bus.debug_rd_w, bus.debug_aluresult};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (run) begin
                bus.cycle_count  <= sat_inc(bus.cycle_count, 1'b1);
                bus.retire_count <= sat_inc(bus.retire_count, evt);
                bus.stall_count  <= sat_inc(bus.stall_count, stall);
                bus.flush_count  <= sat_inc(bus.flush_count, flush);
                bus.fwd_count    <= sat_inc(bus.fwd_count, fwd);
                bus.branch_count <= sat_inc(bus.branch_count, bus.debug_pcsrc_e);
                bus.drop_count   <= sat_inc(bus.drop_count, drop);
            end
            if (drop)
                bus.overflow <= 1'b1;
            st <= (st == RUN)  ? ((bus.ctrl_stop || (STOP_ON_FULL != 0 && drop)) ? HOLD : RUN) :
                  (st == IDLE) ? ((bus.ctrl_start && !bus.ctrl_stop) ? RUN : IDLE) :
                  (st == HOLD) ? ((bus.ctrl_start && !bus.ctrl_stop) ? RUN : HOLD) : IDLE;
        end
    end
endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb_pipe_trace_monitor: directed and random checks against a queue-based model, plus a small saturating variant.
module tb_pipe_trace_monitor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_trace_if #(.CNT_W(32), .TS_W(16)) a();
    pipe_trace_if #(.CNT_W(8),  .TS_W(8))  b();

    pipe_trace_monitor #(.DEPTH(16), .CNT_W(32), .TS_W(16), .STOP_ON_FULL(0)) u_a (.clk(clk), .reset(reset), .bus(a));
    pipe_trace_monitor #(.DEPTH(4),  .CNT_W(8),  .TS_W(8),  .STOP_ON_FULL(1)) u_b (.clk(clk), .reset(reset), .bus(b));

    int tests = 0;
    int failures = 0;

    logic [52:0] m_q[$];
    int m_st;
    longint m_cyc, m_ret, m_stall, m_flush, m_fwd, m_br, m_drop;
    bit m_ovf;

    function automatic longint inc(longint c, bit en);
        return (en && c < 64'hFFFF_FFFF) ? c + 1 : c;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // model of the 16-deep monitor, evaluated on the inputs present just before an edge
    task automatic model_edge();
        int n;
        bit pop, ev;
        if (reset || a.ctrl_clear) begin
            m_q.delete();
            m_st = 0;
            m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0; m_fwd = 0; m_br = 0; m_drop = 0;
            m_ovf = 0;
            return;
        end
        n = m_q.size();
        pop = n > 0 && a.trace_ready;
        ev = m_st == 1 && a.debug_regwrite_w && a.debug_rd_w != 5'd0;
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            if (n < 16 || pop) m_q.push_back({16'(m_cyc), a.debug_rd_w, a.debug_aluresult});
            else begin
                m_drop = inc(m_drop, 1);
                m_ovf = 1;
            end
        end
        if (m_st == 1) begin
            m_cyc   = inc(m_cyc, 1);
            m_ret   = inc(m_ret, ev);
            m_stall = inc(m_stall, a.debug_stall_f || a.debug_stall_d);
            m_flush = inc(m_flush, a.debug_flush_d || a.debug_flush_e);
            m_fwd   = inc(m_fwd, a.debug_forward_ae != 0 || a.debug_forward_be != 0);
            m_br    = inc(m_br, a.debug_pcsrc_e);
        end
        if (m_st == 0 && a.ctrl_start && !a.ctrl_stop) m_st = 1;
        else if (m_st == 1 && a.ctrl_stop) m_st = 2;
        else if (m_st == 2 && a.ctrl_start && !a.ctrl_stop) m_st = 1;
    endtask

    task automatic check_a();
        chk("a_valid",  a.trace_valid, m_q.size() != 0);
        chk("a_data",   a.trace_data, m_q.size() != 0 ? 64'(m_q[0]) : 64'd0);
        chk("a_cycle",  a.cycle_count, m_cyc);
        chk("a_retire", a.retire_count, m_ret);
        chk("a_stall",  a.stall_count, m_stall);
        chk("a_flush",  a.flush_count, m_flush);
        chk("a_fwd",    a.fwd_count, m_fwd);
        chk("a_branch", a.branch_count, m_br);
        chk("a_drop",   a.drop_count, m_drop);
        chk("a_ovf",    a.overflow, m_ovf);
        chk("a_state",  a.state, 64'(m_st));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_a();
    endtask

    task automatic idle_a();
        a.debug_aluresult = '0; a.debug_regwrite_w = 0; a.debug_rd_w = '0;
        a.debug_stall_f = 0; a.debug_stall_d = 0; a.debug_flush_d = 0; a.debug_flush_e = 0;
        a.debug_forward_ae = '0; a.debug_forward_be = '0; a.debug_pcsrc_e = 0;
        a.ctrl_start = 0; a.ctrl_stop = 0; a.ctrl_clear = 0; a.trace_ready = 0;
    endtask

    initial begin
        int r;
        idle_a();
        b.debug_aluresult = '0; b.debug_regwrite_w = 0; b.debug_rd_w = '0;
        b.debug_stall_f = 0; b.debug_stall_d = 0; b.debug_flush_d = 0; b.debug_flush_e = 0;
        b.debug_forward_ae = '0; b.debug_forward_be = '0; b.debug_pcsrc_e = 0;
        b.ctrl_start = 0; b.ctrl_stop = 0; b.ctrl_clear = 0; b.trace_ready = 0;
        reset = 1;
        tick();
        chk("rst_valid", a.trace_valid, 0);
        chk("rst_data", a.trace_data, 0);
        reset = 0;

        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        repeat (3) tick();
        a.debug_regwrite_w = 1; a.debug_rd_w = 5'd5; a.debug_aluresult = 32'hAA;
        tick();
        idle_a();
        chk("first_data", a.trace_data, {16'd3, 5'd5, 32'hAA});
        chk("first_retire", a.retire_count, 1);

        a.ctrl_clear = 1; tick(); a.ctrl_clear = 0;
        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        a.debug_regwrite_w = 1; a.debug_rd_w = 5'd0; a.debug_aluresult = 32'h1234;
        repeat (4) tick();
        idle_a();
        chk("x0_valid", a.trace_valid, 0);
        chk("x0_retire", a.retire_count, 0);
        chk("x0_cycle", a.cycle_count, 4);

        a.ctrl_clear = 1; tick(); a.ctrl_clear = 0;
        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        for (int i = 0; i < 18; i++) begin
            a.debug_regwrite_w = 1; a.debug_rd_w = 5'(i + 1); a.debug_aluresult = $urandom;
            tick();
        end
        idle_a();
        chk("full_drop", a.drop_count, 2);
        chk("full_ovf", a.overflow, 1);
        chk("full_retire", a.retire_count, 18);
        a.ctrl_stop = 1; tick(); a.ctrl_stop = 0;
        a.trace_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_ts", 64'(a.trace_data[52:37]), i);
            tick();
        end
        chk("drain_empty", a.trace_valid, 0);
        idle_a();

        a.ctrl_clear = 1; tick(); a.ctrl_clear = 0;
        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        for (int i = 0; i < 16; i++) begin
            a.debug_regwrite_w = 1; a.debug_rd_w = 5'd9; a.debug_aluresult = $urandom;
            tick();
        end
        a.trace_ready = 1; a.debug_rd_w = 5'd10;
        tick();
        idle_a();
        chk("fullpop_drop", a.drop_count, 0);
        chk("fullpop_head", 64'(a.trace_data[52:37]), 1);

        a.ctrl_clear = 1; tick(); a.ctrl_clear = 0;
        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        a.debug_stall_f = 1; repeat (2) tick(); a.debug_stall_f = 0;
        a.debug_flush_e = 1; tick(); a.debug_flush_e = 0;
        a.debug_forward_ae = 2'b01; repeat (3) tick(); a.debug_forward_ae = 2'b00;
        a.debug_pcsrc_e = 1; tick(); a.debug_pcsrc_e = 0;
        chk("cnt_stall", a.stall_count, 2);
        chk("cnt_flush", a.flush_count, 1);
        chk("cnt_fwd", a.fwd_count, 3);
        chk("cnt_branch", a.branch_count, 1);
        a.ctrl_stop = 1; tick(); a.ctrl_stop = 0;
        a.debug_stall_d = 1; repeat (2) tick();
        chk("hold_stall", a.stall_count, 2);
        a.ctrl_start = 1; tick(); a.ctrl_start = 0;
        tick();
        a.debug_stall_d = 0;
        chk("resume_stall", a.stall_count, 3);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            a.ctrl_start = r < 4;
            a.ctrl_stop = r >= 4 && r < 6;
            a.ctrl_clear = r == 6;
            a.debug_regwrite_w = $urandom_range(0, 3) != 0;
            a.debug_rd_w = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            a.debug_aluresult = $urandom;
            a.debug_stall_f = $urandom_range(0, 3) == 0;
            a.debug_stall_d = $urandom_range(0, 3) == 0;
            a.debug_flush_d = $urandom_range(0, 5) == 0;
            a.debug_flush_e = $urandom_range(0, 5) == 0;
            a.debug_forward_ae = 2'($urandom);
            a.debug_forward_be = 2'($urandom);
            a.debug_pcsrc_e = $urandom_range(0, 3) == 0;
            a.trace_ready = $urandom_range(0, 3) == 0;
            reset = i == 450;
            tick();
        end
        reset = 0;
        idle_a();
        tick();

        b.ctrl_start = 1; tick(); b.ctrl_start = 0;
        chk("b_run", b.state, 2'b01);
        b.debug_regwrite_w = 1; b.debug_rd_w = 5'd7;
        for (int i = 0; i < 4; i++) begin
            b.debug_aluresult = 32'(i);
            tick();
        end
        chk("b_fill_state", b.state, 2'b01);
        chk("b_fill_drop", b.drop_count, 0);
        tick();
        b.debug_regwrite_w = 0;
        chk("b_sof_state", b.state, 2'b10);
        chk("b_sof_drop", b.drop_count, 1);
        chk("b_sof_ovf", b.overflow, 1);
        chk("b_sof_retire", b.retire_count, 5);
        b.ctrl_clear = 1; b.ctrl_start = 1; tick(); b.ctrl_clear = 0; b.ctrl_start = 0;
        chk("b_clr_state", b.state, 2'b00);
        chk("b_clr_cycle", b.cycle_count, 0);
        chk("b_clr_retire", b.retire_count, 0);
        chk("b_clr_drop", b.drop_count, 0);
        chk("b_clr_ovf", b.overflow, 0);
        chk("b_clr_valid", b.trace_valid, 0);

        b.ctrl_start = 1; tick(); b.ctrl_start = 0;
        b.debug_stall_f = 1; repeat (300) tick(); b.debug_stall_f = 0;
        chk("b_sat_cycle", b.cycle_count, 8'hFF);
        chk("b_sat_stall", b.stall_count, 8'hFF);
        b.debug_regwrite_w = 1; b.debug_rd_w = 5'd3; b.debug_aluresult = 32'd5;
        tick();
        b.debug_regwrite_w = 0;
        chk("b_sat_valid", b.trace_valid, 1);
        chk("b_sat_data", b.trace_data, {8'hFF, 5'd3, 32'd5});
        chk("b_sat_retire", b.retire_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/pipe_trace_monitor.md
Name: pipe_trace_monitor

Overview:
- Sits directly downstream of the pipelined RISC-V core. Consumes the core's debug outputs: writeback, hazard, forwarding and branch signals.
- Records every architectural register write into a timestamped trace FIFO and keeps saturating performance counters.
- Gives benches and on-chip debug a cycle-accurate retire stream and hazard statistics without probing core internals.

Parameters:
- DEPTH, 16, trace FIFO entries; power of 2, minimum 2.
- CNT_W, 32, width of every performance counter.
- TS_W, 16, timestamp width; equals the low TS_W bits of cycle_count.
- STOP_ON_FULL, 0, when 1 the monitor moves RUN->HOLD on the first dropped event.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- debug_aluresult  in  32  writeback value.
- debug_regwrite_w  in  1  writeback enable.
- debug_rd_w  in  5  writeback destination register.
- debug_stall_f  in  1  fetch stall.
- debug_stall_d  in  1  decode stall.
- debug_flush_d  in  1  decode flush.
- debug_flush_e  in  1  execute flush.
- debug_forward_ae  in  2  forward select, operand A.
- debug_forward_be  in  2  forward select, operand B.
- debug_pcsrc_e  in  1  taken branch or jump.
- ctrl_start  in  1  pulse: IDLE/HOLD -> RUN.
- ctrl_stop  in  1  pulse: RUN -> HOLD.
- ctrl_clear  in  1  pulse: flush FIFO, zero counters and flags, go to IDLE.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts the head entry.
- trace_data  out  TS_W+37  {timestamp, rd[4:0], value[31:0]}; head entry, first-word-fall-through.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retire_count  out  CNT_W  qualifying writebacks seen in RUN, including dropped ones.
- stall_count  out  CNT_W  RUN cycles with stall_f|stall_d.
- flush_count  out  CNT_W  RUN cycles with flush_d|flush_e.
- fwd_count  out  CNT_W  RUN cycles with forward_ae!=0 or forward_be!=0.
- branch_count  out  CNT_W  RUN cycles with pcsrc_e.
- drop_count  out  CNT_W  events lost to a full FIFO.
- overflow  out  1  sticky; set on the first drop.
- state  out  2  current state: 00 IDLE, 01 RUN, 10 HOLD.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, FIFO empty, trace_valid=0, trace_data=0, all counters=0, overflow=0.
- Control priority is clear > stop > start, evaluated each edge.
  - IDLE: start -> RUN.
  - RUN: stop -> HOLD; with STOP_ON_FULL=1, a drop -> HOLD.
  - HOLD: start -> RUN, counters keep their values.
  - clear from any state -> IDLE.
- Sampling happens only in RUN, on the current edge, using inputs as seen at that edge.
- Counters:
  - Updated at the same edge as sampling; value visible the following cycle.
  - Saturate at 2^CNT_W-1; never wrap.
  - The timestamp taken for an event is cycle_count before the increment, truncated to TS_W bits, and wraps freely.
- Event definition: debug_regwrite_w=1 and debug_rd_w!=0. Writes to x0 are ignored and not counted.
- Push rules:
  - An event is pushed if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - A pop is trace_valid & trace_ready.
  - Otherwise the event is dropped: drop_count+1 and overflow=1.
- Latency: an event sampled at edge N sets trace_valid=1 after edge N. One cycle, no bypass.
- Simultaneous push and pop with the FIFO empty: the pop cannot happen, so the push succeeds normally.
- Pops are allowed in every state, including IDLE and HOLD. trace_data is stable while trace_valid=1 and trace_ready=0.
- Occupancy uses pointer wrap with an extra MSB; full = DEPTH entries.
- ctrl_clear in the same cycle as an event: clear wins and the event is discarded.
- A reset asserted mid-stream discards all entries at that edge. No partial entry is ever output.

Test Plan:
- Reset, start, then a single writeback rd=5, value=0x0000_00AA at RUN cycle 3 -> next cycle trace_valid=1, trace_data={16'd3, 5'd5, 32'hAA}, retire_count=1.
- Writebacks with rd=0 for 4 cycles -> trace_valid stays 0, retire_count=0, cycle_count=4.
- DEPTH=16, 18 back-to-back events with trace_ready=0 -> 16 entries stored, drop_count=2, overflow=1, retire_count=18. Then drain 16 entries in order with timestamps 0..15.
- FIFO full and an event arrives with trace_ready=1 on the same edge -> no drop; occupancy stays 16; the head advances.
- Stall for 2 cycles, flush for 1, forward_ae=01 for 3, pcsrc_e for 1 -> stall_count=2, flush_count=1, fwd_count=3, branch_count=1. Counts stay frozen after stop (HOLD), resume after start.
- STOP_ON_FULL=1, overflow the FIFO -> state=HOLD one edge after the first drop. Then ctrl_clear together with ctrl_start -> IDLE, every counter 0, FIFO empty, overflow=0.
